// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the round-robin BCD conversion scheduler.
// Optional hundreds output is enabled by defining BCD_HUNDREDS_EN.
package bcd_sched_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam int BCD_DIGIT_W = 4;
   localparam int BCD_DIGITS  = 3;
   localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;
endpackage

// File: rtl/bcd_dabble_seq.sv
// Iterative double-dabble engine: one add-3/shift step per clock, WIDTH steps per operand.
// o_done marks the cycle whose clock edge performs the final step; digits shown are post-step.
module bcd_dabble_seq
   import bcd_sched_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_operand,
   output logic             o_done,
`ifdef BCD_HUNDREDS_EN
   output logic [3:0]       o_hund,
`endif
   output logic [3:0]       o_tens,
   output logic [3:0]       o_ones
);
   localparam int SH_W = WIDTH + BCD_DIGITS * BCD_DIGIT_W;

   logic [SH_W-1:0] r_sh;
   logic [3:0]      r_cnt;
   logic            r_run;
   logic [SH_W-1:0] w_next;

   function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] s);
      logic [SH_W-1:0] t;
      t = s;
      for (int d = 0; d < BCD_DIGITS; d++) begin
         if (t[WIDTH + d*BCD_DIGIT_W +: BCD_DIGIT_W] >= ADD3_THRESH)
            t[WIDTH + d*BCD_DIGIT_W +: BCD_DIGIT_W] =
               t[WIDTH + d*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
      end
      return {t[SH_W-2:0], 1'b0};
   endfunction

   assign w_next = dabble_step(r_sh);
   assign o_done = r_run && (r_cnt == 4'(WIDTH - 1));
`ifdef BCD_HUNDREDS_EN
   assign o_hund = w_next[WIDTH+8 +: 4];
`endif
   assign o_tens = w_next[WIDTH+4 +: 4];
   assign o_ones = w_next[WIDTH   +: 4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh  <= '0;
         r_cnt <= '0;
         r_run <= 1'b0;
      end else if (i_start) begin
         r_sh  <= {{(BCD_DIGITS*BCD_DIGIT_W){1'b0}}, i_operand};
         r_cnt <= '0;
         r_run <= 1'b1;
      end else if (r_run) begin
         r_sh  <= w_next;
         r_cnt <= r_cnt + 4'd1;
         if (o_done)
            r_run <= 1'b0;
      end
   end
endmodule

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one double-dabble engine among N_REQ requesters.
// Define BCD_HUNDREDS_EN to expose the hundreds digit port.
module bcd_conv_scheduler
   import bcd_sched_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] bin_in,
   output logic [N_REQ-1:0]       ack,
   output logic [2:0]             grant_id,
   output logic                   busy,
   output logic [3:0]             tens,
   output logic [3:0]             ones
`ifdef BCD_HUNDREDS_EN
   ,
   output logic [3:0]             hundreds
`endif
);
   state_t             r_state, w_state_nxt;
   logic [2:0]         r_ptr, r_gid;
   logic               r_busy;
   logic [N_REQ-1:0]   r_ack, w_ack_vec;
   logic [3:0]         r_tens, r_ones;
   logic               w_found, w_start, w_done;
   logic [2:0]         w_gnt;
   logic [3:0]         w_sum;
   logic [WIDTH-1:0]   w_operand;
   logic [3:0]         w_tens, w_ones;
`ifdef BCD_HUNDREDS_EN
   logic [3:0]         r_hund, w_hund;
   assign hundreds = r_hund;
`endif

   // Search starts one past the last granted requester and wraps around.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_sum   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         w_sum = {1'b0, r_ptr} + 4'(i);
         if (w_sum >= 4'(N_REQ))
            w_sum = w_sum - 4'(N_REQ);
         for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && req[k] && (w_sum == 4'(k))) begin
               w_found = 1'b1;
               w_gnt   = 3'(k);
            end
         end
      end
   end

   always_comb begin
      w_operand = '0;
      w_ack_vec = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_gnt == 3'(k))
            w_operand = bin_in[k*WIDTH +: WIDTH];
         w_ack_vec[k] = (r_gid == 3'(k));
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_found) w_state_nxt = SHIFT;
         SHIFT:   if (w_done)  w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_start = (r_state == IDLE) && w_found;

   bcd_dabble_seq #(.WIDTH(WIDTH)) u_dabble (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (w_start),
      .i_operand (w_operand),
      .o_done    (w_done),
`ifdef BCD_HUNDREDS_EN
      .o_hund    (w_hund),
`endif
      .o_tens    (w_tens),
      .o_ones    (w_ones)
   );

   // Digits and ack are loaded together so the digits are already valid during the ack cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= 3'(N_REQ - 1);
         r_gid   <= '0;
         r_busy  <= 1'b0;
         r_ack   <= '0;
         r_tens  <= '0;
         r_ones  <= '0;
`ifdef BCD_HUNDREDS_EN
         r_hund  <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= '0;
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_gid  <= w_gnt;
                  r_ptr  <= w_gnt;
                  r_busy <= 1'b1;
               end
            end
            SHIFT: begin
               if (w_done) begin
                  r_ack  <= w_ack_vec;
                  r_tens <= w_tens;
                  r_ones <= w_ones;
`ifdef BCD_HUNDREDS_EN
                  r_hund <= w_hund;
`endif
               end
            end
            DONE:    r_busy <= 1'b0;
            default: ;
         endcase
      end
   end

   assign ack      = r_ack;
   assign grant_id = r_gid;
   assign busy     = r_busy;
   assign tens     = r_tens;
   assign ones     = r_ones;
endmodule
